// File: rtl/fetch_req_ctrl.sv
`default_nettype none
// fetch_req_ctrl: credit-based ICache fetch-request scheduler feeding the IF1->ID fetch FIFO.
// Requests issue only when a FIFO slot is guaranteed; stale responses after a redirect are dropped.
module fetch_req_ctrl #(
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] PC_RESET        = 32'h1c00_0000,
   parameter int          CNT_W           = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   input  logic             halt,
   output logic             icache_req_valid,
   input  logic             icache_req_ready,
   output logic [31:0]      icache_req_pc,
   input  logic             icache_resp_valid,
   output logic             fifo_write_en,
   input  logic             fifo_pop_en,
   output logic             fifo_flush,
   output logic [CNT_W-1:0] occupancy,
   output logic [CNT_W-1:0] outstanding,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_e;

   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] MAXOUT_C = CNT_W'(MAX_OUTSTANDING);

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] out_q, out_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic [CNT_W-1:0] live;
   logic [CNT_W:0]   credit_sum;
   logic             has_credit;
   logic             req_valid;
   logic             handshake;
   logic             drop_pending;
   logic             write_en;
   logic [31:0]      pc_seq;

   // Live requests are the ones whose responses will actually land in the FIFO.
   assign live         = out_q - drop_q;
   assign credit_sum   = {1'b0, occ_q} + {1'b0, live};
   assign has_credit   = credit_sum < DEPTH_C;
   assign req_valid    = (state_q == ST_RUN) && !halt && !redirect && has_credit
                         && (out_q < MAXOUT_C);
   assign handshake    = req_valid && icache_req_ready;
   assign drop_pending = (drop_q != '0);
   assign write_en     = icache_resp_valid && !drop_pending && !redirect;
   assign pc_seq       = {pc_q[31:3] + 29'd1, 3'b000};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      occ_d   = occ_q;
      out_d   = out_q + CNT_W'(handshake) - CNT_W'(icache_resp_valid);
      drop_d  = drop_q;

      if (redirect) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  state_d = halt ? ST_HALT : ST_RUN;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
         endcase
      end

      if (redirect) begin
         pc_d = redirect_pc;
      end else if (handshake) begin
         pc_d = pc_seq;
      end

      if (redirect) begin
         occ_d = '0;
      end else begin
         occ_d = occ_q + CNT_W'(write_en) - CNT_W'(fifo_pop_en);
      end

      // Everything in flight at a redirect is stale, including a response arriving right now.
      if (redirect) begin
         drop_d = out_q - CNT_W'(icache_resp_valid);
      end else if (icache_resp_valid && drop_pending) begin
         drop_d = drop_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         pc_q    <= PC_RESET;
         occ_q   <= '0;
         out_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         occ_q   <= occ_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
      end
   end

   assign icache_req_valid = req_valid;
   assign icache_req_pc    = pc_q;
   assign fifo_write_en    = write_en;
   assign fifo_flush       = redirect;
   assign occupancy        = occ_q;
   assign outstanding      = out_q;
   assign drop_cnt         = drop_q;
   assign state            = state_q;

   always @(posedge clk) begin
      if (rstn) begin
         a_credit : assert (credit_sum <= DEPTH_C);
         a_maxout : assert (out_q <= MAXOUT_C);
         a_drop   : assert (drop_q <= out_q);
         a_resp   : assert (!(icache_resp_valid && (out_q == '0)));
         a_pop    : assert (!(fifo_pop_en && (occ_q == '0)));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_req_ctrl.sv
`default_nettype none
// tb_fetch_req_ctrl: scoreboard bench; a queue-based reference model predicts every cycle's outputs
// and each request PC, and a negedge monitor pops and compares them against fetch_req_ctrl.
module tb_fetch_req_ctrl;

   localparam int          FIFO_DEPTH      = 2;
   localparam int          MAX_OUTSTANDING = 2;
   localparam int          CNT_W           = 2;
   localparam logic [31:0] PC_RESET        = 32'h1c00_0000;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             redirect = 1'b0;
   logic [31:0]      redirect_pc = '0;
   logic             halt = 1'b0;
   logic             icache_req_ready = 1'b0;
   logic             icache_resp_valid = 1'b0;
   logic             fifo_pop_en = 1'b0;
   logic             icache_req_valid;
   logic [31:0]      icache_req_pc;
   logic             fifo_write_en;
   logic             fifo_flush;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_cnt;
   logic [1:0]       state;

   always #5 clk = ~clk;

   fetch_req_ctrl #(
      .FIFO_DEPTH      (FIFO_DEPTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .PC_RESET        (PC_RESET),
      .CNT_W           (CNT_W)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .halt              (halt),
      .icache_req_valid  (icache_req_valid),
      .icache_req_ready  (icache_req_ready),
      .icache_req_pc     (icache_req_pc),
      .icache_resp_valid (icache_resp_valid),
      .fifo_write_en     (fifo_write_en),
      .fifo_pop_en       (fifo_pop_en),
      .fifo_flush        (fifo_flush),
      .occupancy         (occupancy),
      .outstanding       (outstanding),
      .drop_cnt          (drop_cnt),
      .state             (state)
   );

   typedef struct packed {
      logic             v;
      logic [31:0]      pc;
      logic             we;
      logic             fl;
      logic [CNT_W-1:0] occ;
      logic [CNT_W-1:0] outs;
      logic [CNT_W-1:0] drop;
      logic [1:0]       st;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pc_q[$];
   int          n_vec = 0;
   int          n_miss = 0;
   int          n_we = 0;

   // Reference model: in-flight requests oldest first (1 = stale), FIFO fill, fetch PC, mode 0/1/2.
   bit          m_stale[$];
   int          m_fifo = 0;
   logic [31:0] m_pc = PC_RESET;
   int          m_mode = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int count_stale();
      int n;
      n = 0;
      foreach (m_stale[i]) if (m_stale[i]) n++;
      return n;
   endfunction

   task automatic step(input bit rd, input logic [31:0] rpc, input bit hl, input bit rdy,
                       input bit rsp_req, input bit pop_req);
      bit   r, p, v, hs, we;
      int   drops, live;
      exp_t e;
      r     = rsp_req && (m_stale.size() > 0);
      p     = pop_req && (m_fifo > 0);
      drops = count_stale();
      live  = m_stale.size() - drops;
      v     = (m_mode == 1) && !hl && !rd && (m_fifo + live < FIFO_DEPTH)
              && (m_stale.size() < MAX_OUTSTANDING);
      hs    = v && rdy;
      we    = r && !rd && !m_stale[0];

      e.v    = v;
      e.pc   = m_pc;
      e.we   = we;
      e.fl   = rd;
      e.occ  = CNT_W'(m_fifo);
      e.outs = CNT_W'(m_stale.size());
      e.drop = CNT_W'(drops);
      e.st   = 2'(m_mode);

      redirect          = rd;
      redirect_pc       = rpc;
      halt              = hl;
      icache_req_ready  = rdy;
      icache_resp_valid = r;
      fifo_pop_en       = p;
      exp_q.push_back(e);
      if (hs) pc_q.push_back(m_pc);

      if (r) void'(m_stale.pop_front());
      if (rd) foreach (m_stale[i]) m_stale[i] = 1'b1;
      if (hs) m_stale.push_back(1'b0);
      m_fifo = rd ? 0 : m_fifo + int'(we) - int'(p);
      if (rd) m_pc = rpc;
      else if (hs) m_pc = {m_pc[31:3] + 29'd1, 3'b000};
      if (rd || m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && hl) m_mode = 2;

      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && (m_stale.size() != 0 || m_fifo != 0); k++) step(0, '0, 0, 0, 1, 1);
      check("drain_out", 32'(outstanding), 32'd0);
      check("drain_occ", 32'(occupancy), 32'd0);
   endtask

   task automatic fill_two();
      for (int k = 0; k < 20 && m_stale.size() != 2; k++) step(0, '0, 0, 1, 0, 1);
      check("fill_out2", 32'(outstanding), 32'd2);
   endtask

   always @(negedge clk) begin
      exp_t e, a;
      a.v    = icache_req_valid;
      a.pc   = icache_req_pc;
      a.we   = fifo_write_en;
      a.fl   = fifo_flush;
      a.occ  = occupancy;
      a.outs = outstanding;
      a.drop = drop_cnt;
      a.st   = state;
      if (rstn && fifo_write_en) n_we++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (a !== e) begin
            n_miss++;
            $display("FAIL status @%0t: got v=%b pc=%08h we=%b fl=%b occ=%0d out=%0d drop=%0d st=%0d, expected v=%b pc=%08h we=%b fl=%b occ=%0d out=%0d drop=%0d st=%0d",
                     $time, a.v, a.pc, a.we, a.fl, a.occ, a.outs, a.drop, a.st,
                     e.v, e.pc, e.we, e.fl, e.occ, e.outs, e.drop, e.st);
         end
      end
      if (rstn && icache_req_valid && icache_req_ready) begin
         n_vec++;
         if (pc_q.size() == 0) begin
            n_miss++;
            $display("FAIL req_pc @%0t: got unexpected handshake at %08h, expected none", $time, icache_req_pc);
         end else if (icache_req_pc !== pc_q[0]) begin
            n_miss++;
            $display("FAIL req_pc @%0t: got %08h, expected %08h", $time, icache_req_pc, pc_q[0]);
            void'(pc_q.pop_front());
         end else begin
            void'(pc_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish, expected finish within budget");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(icache_req_valid), 32'd0);
      check("rst_pc", icache_req_pc, PC_RESET);
      check("rst_we", 32'(fifo_write_en), 32'd0);
      check("rst_flush", 32'(fifo_flush), 32'd0);
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_out", 32'(outstanding), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Reset start: two requests, two writes, FIFO full
      repeat (8) step(0, '0, 0, 1, 1, 0);
      check("start_occ", 32'(occupancy), 32'd2);
      check("start_we_count", 32'(n_we), 32'd2);
      check("start_out", 32'(outstanding), 32'd0);

      // Steady flow with a pop every cycle
      repeat (12) step(0, '0, 0, 1, 1, 1);

      // Redirect with two requests in flight
      fill_two();
      step(1, 32'h1c00_0104, 0, 1, 0, 0);
      check("redir_drop", 32'(drop_cnt), 32'd2);
      check("redir_occ", 32'(occupancy), 32'd0);
      repeat (6) step(0, '0, 0, 1, 1, 0);

      // Redirect coincident with a response
      drain();
      fill_two();
      step(1, 32'h2000_0040, 0, 1, 1, 0);
      check("coinc_drop", 32'(drop_cnt), 32'd1);
      check("coinc_occ", 32'(occupancy), 32'd0);
      repeat (4) step(0, '0, 0, 1, 1, 1);

      // Halt with one request in flight
      drain();
      step(0, '0, 0, 1, 0, 0);
      step(0, '0, 1, 0, 1, 0);
      check("halt_occ", 32'(occupancy), 32'd1);
      repeat (4) step(0, '0, 1, 1, 0, 0);
      check("halt_state", 32'(state), 32'd2);
      step(1, 32'h1c00_0200, 0, 1, 0, 0);
      check("halt_resume_state", 32'(state), 32'd1);
      repeat (3) step(0, '0, 0, 1, 1, 1);

      // PC wrap with a three-cycle ready stall
      drain();
      step(1, 32'hffff_fff8, 0, 0, 0, 0);
      repeat (3) step(0, '0, 0, 0, 0, 0);
      step(0, '0, 0, 1, 0, 0);
      step(0, '0, 0, 1, 0, 0);
      repeat (4) step(0, '0, 0, 1, 1, 1);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(99) < 5, {$urandom()}, $urandom_range(99) < 10,
              $urandom_range(99) < 70, $urandom_range(99) < 60, $urandom_range(99) < 50);
      end

      check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
      check("pc_queue_empty", 32'(pc_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
